// File: rtl/lcd_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// lcd_read_ctrl_if
//
// Request/response bundle between the LCD init/line sequencer (master) and the
// HD44780 read controller (slave).
//
// Handshake: the master raises iStart for one or more cycles with iRS/iPoll
// valid alongside it. The slave samples iStart only while idle (oBusy=0); a
// request seen while busy is dropped, never queued. Once accepted, oBusy stays
// high until the cycle after the single-cycle oDone pulse. oDATA is valid
// during oDone and holds until the next read strobe. oTimeout, when enabled,
// pulses together with oDone for an abandoned poll.
//
// Signals:
//   iStart   master->slave  request strobe
//   iRS      master->slave  register select for the request
//   iPoll    master->slave  repeat busy-flag reads until BF clears
//   oDATA    slave->master  last byte sampled from the LCD bus
//   oDone    slave->master  one-cycle completion pulse
//   oBusy    slave->master  transaction in progress / bus owned for reading
//   oTimeout slave->master  poll abandoned after the read limit
// -----------------------------------------------------------------------------
interface lcd_read_ctrl_if;
    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic [7:0] oDATA;
    logic       oDone;
    logic       oBusy;
    logic       oTimeout;

    modport master (
        output iStart, iRS, iPoll,
        input  oDATA, oDone, oBusy, oTimeout
    );

    modport slave (
        input  iStart, iRS, iPoll,
        output oDATA, oDone, oBusy, oTimeout
    );
endinterface

// File: rtl/lcd_read_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_read_ctrl
//
// Read side of the HD44780 character-LCD interface. Each accepted request
// runs one RW=1 bus cycle: RS/RW setup, an EN strobe, then a hold period.
// The data bus is sampled on the edge that drops EN. In poll mode the cycle
// repeats as a busy-flag read (RS forced to 0) until bit 7 of the sampled
// byte is clear, so the sequencer can wait on the real ready condition.
//
// The block never drives LCD_DATA; the top level keeps the bus tri-stated
// whenever oBusy is high and uses oBusy to arbitrate against the writer.
//
// Optional feature macro: LCD_RD_TIMEOUT_EN
//   defined   : a 16-bit read counter bounds each poll to TIMEOUT_POLLS
//               busy reads; on expiry oDone and oTimeout pulse together.
//   undefined : polling is unbounded and oTimeout is tied low.
//
// Parameters:
//   SETUP_CYC     1..255  cycles RS/RW are stable before EN rises
//   EN_WIDTH      2..255  cycles EN is held high
//   HOLD_CYC      1..255  cycles after EN falls before repeat or done
//   TIMEOUT_POLLS         busy reads allowed per poll (macro builds only)
//
// Ports:
//   iCLK         clock
//   iRST_N       asynchronous active-low reset
//   bus          request/response bundle (slave side)
//   LCD_DATA_IN  LCD data bus as seen through the top-level tri-state
//   LCD_RW       1 while a transaction is in progress
//   LCD_EN       enable strobe
//   LCD_RS       register select of the current transaction
//   oDbgState    current FSM state encoding
// -----------------------------------------------------------------------------
module lcd_read_ctrl #(
    parameter int SETUP_CYC     = 4,
    parameter int EN_WIDTH      = 16,
    parameter int HOLD_CYC      = 4
`ifdef LCD_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_POLLS = 1024
`endif
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    lcd_read_ctrl_if.slave   bus,
    input  logic [7:0]       LCD_DATA_IN,
    output logic             LCD_RW,
    output logic             LCD_EN,
    output logic             LCD_RS,
    output logic [2:0]       oDbgState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        EN_LO = 3'd3,
        DONE  = 3'd4
    } state_t;

    // The phase counter is loaded with (cycles - 1) on entry to a phase and
    // the phase ends on the edge where it reads zero, so a phase of N cycles
    // occupies exactly N clock periods.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] EN_LOAD    = 8'(EN_WIDTH - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC - 1);

`ifdef LCD_RD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_POLLS);
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        rs_q,    rs_d;
    logic        poll_q,  poll_d;
    logic [7:0]  data_q,  data_d;

`ifdef LCD_RD_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        timeout_q,  timeout_d;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rs_q    <= 1'b0;
            poll_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            poll_q  <= poll_d;
            data_q  <= data_d;
        end
    end

`ifdef LCD_RD_TIMEOUT_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            poll_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        poll_d  = poll_q;
        data_d  = data_q;
`ifdef LCD_RD_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    // A poll is always a busy-flag read, whatever iRS says.
                    rs_d    = bus.iPoll ? 1'b0 : bus.iRS;
                    poll_d  = bus.iPoll;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
`ifdef LCD_RD_TIMEOUT_EN
                    poll_cnt_d = 16'd0;
                    timeout_d  = 1'b0;
`endif
                end
            end

            SETUP: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = EN_LOAD;
                    state_d = EN_HI;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            EN_HI: begin
                if (cnt_q == 8'd0) begin
                    // Sample on the same edge that drops EN; the LCD keeps
                    // driving for tDHR after EN falls.
                    data_d  = LCD_DATA_IN;
                    cnt_d   = HOLD_LOAD;
                    state_d = EN_LO;
`ifdef LCD_RD_TIMEOUT_EN
                    if (poll_q) begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            EN_LO: begin
                if (cnt_q == 8'd0) begin
                    if (poll_q && data_q[7]) begin
`ifdef LCD_RD_TIMEOUT_EN
                        if (poll_cnt_q >= TIMEOUT_LIM) begin
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            cnt_d   = SETUP_LOAD;
                            state_d = SETUP;
                        end
`else
                        // Still busy: rerun the read with RS/RW untouched.
                        cnt_d   = SETUP_LOAD;
                        state_d = SETUP;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from state so that reset clears them immediately.
    // -------------------------------------------------------------------------
    assign LCD_RW     = (state_q != IDLE);
    assign LCD_EN     = (state_q == EN_HI);
    assign LCD_RS     = rs_q;
    assign oDbgState  = state_q;

    assign bus.oDATA  = data_q;
    assign bus.oDone  = (state_q == DONE);
    assign bus.oBusy  = (state_q != IDLE);

`ifdef LCD_RD_TIMEOUT_EN
    assign bus.oTimeout = (state_q == DONE) && timeout_q;
`else
    assign bus.oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_read_ctrl
//
// Directed bench for lcd_read_ctrl. u_dut uses default timing; u_fast uses
// the minimum timing (1/2/1). Cycle index k counts negedges after the edge
// E0 that accepts iStart, so k=n is the cycle following edge E0+n.
// -----------------------------------------------------------------------------
module tb_lcd_read_ctrl;

    localparam int MAXK = 400;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_read_ctrl_if m_if ();
    lcd_read_ctrl_if f_if ();

    logic [7:0] lcd_data;
    logic       m_rw, m_en, m_rs;
    logic       f_rw, f_en, f_rs;
    logic [2:0] m_st, f_st;

    lcd_read_ctrl #(
        .SETUP_CYC (4),
        .EN_WIDTH  (16),
        .HOLD_CYC  (4)
`ifdef LCD_RD_TIMEOUT_EN
        ,
        .TIMEOUT_POLLS (3)
`endif
    ) u_dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .bus         (m_if),
        .LCD_DATA_IN (lcd_data),
        .LCD_RW      (m_rw),
        .LCD_EN      (m_en),
        .LCD_RS      (m_rs),
        .oDbgState   (m_st)
    );

    lcd_read_ctrl #(
        .SETUP_CYC (1),
        .EN_WIDTH  (2),
        .HOLD_CYC  (1)
    ) u_fast (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .bus         (f_if),
        .LCD_DATA_IN (lcd_data),
        .LCD_RW      (f_rw),
        .LCD_EN      (f_en),
        .LCD_RS      (f_rs),
        .oDbgState   (f_st)
    );

    // LCD model: one byte is presented per EN pulse, popped on EN rise.
    logic [7:0] resp_q[$];

    int tests = 0;
    int fails = 0;

    // Results of the last run_read
    int         r_done_k;
    int         r_ndone;
    int         r_pulses;
    int         r_en_first;
    int         r_en_last;
    int         r_rs_bad;
    int         r_to;
    int         r_busy_after;
    logic [7:0] r_data;

    typedef struct {
        bit         rs;
        bit         poll;
        int         n_busy;
        logic [7:0] fin;
        bit         exp_rs;
        int         exp_done;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_start(input bit fast, input bit st, input bit rs, input bit poll);
        if (fast) begin
            f_if.iStart = st;
            f_if.iRS    = rs;
            f_if.iPoll  = poll;
        end else begin
            m_if.iStart = st;
            m_if.iRS    = rs;
            m_if.iPoll  = poll;
        end
    endtask

    // Issue one request and observe it until a few cycles past oDone.
    // inj_k >= 0 re-asserts iStart during cycle inj_k (must be ignored).
    task automatic run_read(input bit fast, input bit rs, input bit poll,
                            input int inj_k, input bit exp_rs);
        bit         en, prev_en, rw, rsx, busy, done, to;
        logic [7:0] dat;
        r_done_k     = -1;
        r_ndone      = 0;
        r_pulses     = 0;
        r_en_first   = -1;
        r_en_last    = -1;
        r_rs_bad     = 0;
        r_to         = 0;
        r_busy_after = -1;
        r_data       = 8'hxx;
        prev_en      = 1'b0;
        @(negedge clk);
        drive_start(fast, 1'b1, rs, poll);
        @(posedge clk);
        for (int k = 0; k < MAXK; k++) begin
            @(negedge clk);
            en   = fast ? f_en : m_en;
            rw   = fast ? f_rw : m_rw;
            rsx  = fast ? f_rs : m_rs;
            busy = fast ? f_if.oBusy : m_if.oBusy;
            done = fast ? f_if.oDone : m_if.oDone;
            to   = fast ? f_if.oTimeout : m_if.oTimeout;
            dat  = fast ? f_if.oDATA : m_if.oDATA;
            drive_start(fast, (k == inj_k), rs, poll);
            if (en && !prev_en) begin
                r_pulses++;
                if (r_en_first < 0) r_en_first = k;
                if (resp_q.size() > 0) lcd_data = resp_q.pop_front();
            end
            if (en) r_en_last = k;
            if ((rw && (rsx != exp_rs)) || (busy != rw)) r_rs_bad++;
            if (to) r_to++;
            if (done) begin
                r_ndone++;
                if (r_done_k < 0) begin
                    r_done_k = k;
                    r_data   = dat;
                end
            end
            if (r_done_k >= 0 && k == r_done_k + 1) r_busy_after = int'(busy);
            prev_en = en;
            if (r_done_k >= 0 && k >= r_done_k + 6) break;
        end
        if (r_done_k < 0) check("done_within_budget", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: rs, poll, busy reads, final byte, exp RS, exp done k, exp EN pulses
        vecs[0] = '{1'b1, 1'b0, 0, 8'h41, 1'b1, 24, 1};
        vecs[1] = '{1'b0, 1'b0, 0, 8'hA3, 1'b0, 24, 1};
`ifdef LCD_RD_TIMEOUT_EN
        vecs[2] = '{1'b1, 1'b1, 2, 8'h05, 1'b0, 72, 3};
`else
        vecs[2] = '{1'b1, 1'b1, 3, 8'h05, 1'b0, 96, 4};
`endif
        vecs[3] = '{1'b0, 1'b1, 0, 8'h7F, 1'b0, 24, 1};
        vecs[4] = '{1'b1, 1'b0, 0, 8'h00, 1'b1, 24, 1};

        // Clock/reset
        rst_n    = 1'b0;
        lcd_data = 8'h00;
        drive_start(1'b0, 1'b0, 1'b0, 1'b0);
        drive_start(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_odata",   int'(m_if.oDATA),    0);
        check("rst_odone",   int'(m_if.oDone),    0);
        check("rst_obusy",   int'(m_if.oBusy),    0);
        check("rst_otimeout",int'(m_if.oTimeout), 0);
        check("rst_en",      int'(m_en),          0);
        check("rst_rw",      int'(m_rw),          0);
        check("rst_rs",      int'(m_rs),          0);
        check("rst_state",   int'(m_st),          0);

        // Table-driven reads
        foreach (vecs[i]) begin
            resp_q.delete();
            for (int b = 0; b < vecs[i].n_busy; b++) resp_q.push_back(8'h85);
            resp_q.push_back(vecs[i].fin);
            run_read(1'b0, vecs[i].rs, vecs[i].poll, -1, vecs[i].exp_rs);
            check($sformatf("v%0d_done_k", i),   r_done_k,     vecs[i].exp_done);
            check($sformatf("v%0d_ndone", i),    r_ndone,      1);
            check($sformatf("v%0d_pulses", i),   r_pulses,     vecs[i].exp_pulses);
            check($sformatf("v%0d_en_first", i), r_en_first,   4);
            check($sformatf("v%0d_en_last", i),  r_en_last,    vecs[i].exp_done - 5);
            check($sformatf("v%0d_data", i),     int'(r_data), int'(vecs[i].fin));
            check($sformatf("v%0d_rs_rw", i),    r_rs_bad,     0);
            check($sformatf("v%0d_busy_fall", i),r_busy_after, 0);
            check($sformatf("v%0d_timeout", i),  r_to,         0);
        end

        // Ignored start in the middle of a read
        resp_q.delete();
        resp_q.push_back(8'h5A);
        run_read(1'b0, 1'b1, 1'b0, 10, 1'b1);
        check("ign_done_k", r_done_k, 24);
        check("ign_ndone",  r_ndone,  1);
        check("ign_pulses", r_pulses, 1);
        check("ign_data",   int'(r_data), 8'h5A);

        // Reset during EN_HI
        resp_q.delete();
        lcd_data = 8'hEE;
        @(negedge clk);
        drive_start(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) drive_start(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("rstmid_pre_en", int'(m_en), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_en",    int'(m_en),       0);
        check("rstmid_rw",    int'(m_rw),       0);
        check("rstmid_busy",  int'(m_if.oBusy), 0);
        check("rstmid_odata", int'(m_if.oDATA), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstmid_no_done", int'(m_if.oDone), 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("rstmid_idle_no_done", int'(m_if.oDone), 0);
        end
        resp_q.push_back(8'h3C);
        run_read(1'b0, 1'b1, 1'b0, -1, 1'b1);
        check("rstmid_after_done_k", r_done_k, 24);
        check("rstmid_after_data",   int'(r_data), 8'h3C);

        // Poll that never clears
        resp_q.delete();
`ifdef LCD_RD_TIMEOUT_EN
        for (int b = 0; b < 8; b++) resp_q.push_back(8'h80);
        run_read(1'b0, 1'b0, 1'b1, -1, 1'b0);
        check("to_done_k", r_done_k, 72);
        check("to_pulses", r_pulses, 3);
        check("to_pulse",  r_to,     1);
        check("to_ndone",  r_ndone,  1);
        check("to_data",   int'(r_data), 8'h80);
`else
        for (int b = 0; b < 5; b++) resp_q.push_back(8'h80);
        resp_q.push_back(8'h00);
        run_read(1'b0, 1'b0, 1'b1, -1, 1'b0);
        check("nto_done_k", r_done_k, 144);
        check("nto_pulses", r_pulses, 6);
        check("nto_pulse",  r_to,     0);
        check("nto_data",   int'(r_data), 8'h00);
`endif

        // Minimum timing instance
        resp_q.delete();
        resp_q.push_back(8'hC3);
        run_read(1'b1, 1'b1, 1'b0, -1, 1'b1);
        check("fast_done_k",   r_done_k,   4);
        check("fast_en_first", r_en_first, 1);
        check("fast_en_last",  r_en_last,  2);
        check("fast_pulses",   r_pulses,   1);
        check("fast_data",     int'(r_data), 8'hC3);
        check("fast_busy_fall",r_busy_after, 0);
        check("fast_rs_rw",    r_rs_bad,   0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_read_ctrl.md
# lcd_read_ctrl

Read-side companion to the HD44780 character-LCD write path. Performs one LCD read bus cycle (RW=1) per request: either a busy-flag/address read (RS=0) or a DDRAM/CGRAM data read (RS=1). Returns the sampled byte through a start/done handshake. A poll mode repeats busy-flag reads until BF clears, so the init/line sequencer can replace its fixed inter-command delay with a true ready check. The top level owns the LCD_DATA tri-state and arbitrates between this block and the write controller using oBusy.

## Interface
- SETUP_CYC, 4: cycles RS/RW held stable before EN rises (tAS); range 1..255
- EN_WIDTH, 16: cycles LCD_EN held high (PWEH, tDDR); range 2..255
- HOLD_CYC, 4: cycles after EN falls before the next cycle or done (tAH/tcycE); range 1..255
- TIMEOUT_POLLS, 1024: maximum busy reads per poll request (only with LCD_RD_TIMEOUT_EN)
- iCLK  in  1  clock
- iRST_N  in  1  asynchronous, active-low reset
- iStart  in  1  request; sampled only in IDLE
- iRS  in  1  register select for the request; captured with iStart
- iPoll  in  1  1 = repeat BF reads until bit7=0; captured with iStart; forces RS=0
- oDATA  out  8  last sampled byte; held until next sample
- oDone  out  1  one-cycle pulse: transaction complete, oDATA valid
- oBusy  out  1  high from the cycle after iStart is accepted until the cycle after oDone
- oTimeout  out  1  one-cycle pulse coincident with oDone when a poll was abandoned (0 without macro)
- LCD_DATA_IN  in  8  LCD data bus as seen through the top-level tri-state
- LCD_RW  out  1  1 during a transaction, 0 in IDLE
- LCD_EN  out  1  enable strobe
- LCD_RS  out  1  register select

## Operation
- States: IDLE, SETUP, EN_HI, EN_LO, DONE. A single down-counter, width clog2(255+1)=8 bits, times each phase.
- IDLE: LCD_EN=0, LCD_RW=0, oBusy=0. On iStart=1, capture RS (iPoll ? 0 : iRS) and the poll flag. Go to SETUP with LCD_RW=1 and LCD_RS set.
- SETUP: SETUP_CYC cycles, then EN_HI.
- EN_HI: LCD_EN=1 for EN_WIDTH cycles. On the edge that leaves EN_HI, LCD_DATA_IN is latched into oDATA and LCD_EN goes 0.
- EN_LO: HOLD_CYC cycles. Exit rules:
  - poll flag set and oDATA[7]=1: return to SETUP. RS and RW stay unchanged.
  - otherwise: go to DONE.
- DONE: oDone=1 for one cycle. Next state is IDLE, where LCD_RW returns to 0.
- iStart asserted outside IDLE is ignored. It is not queued.
- The block never drives LCD_DATA. The top level must tri-state the bus whenever oBusy=1.

## Timing
- Reset values: oDATA=8'h00, oDone=0, oBusy=0, oTimeout=0, LCD_EN=0, LCD_RW=0, LCD_RS=0, state IDLE. Reset acts asynchronously. Asserting it mid-transaction drops LCD_EN immediately and discards the in-progress read.
- Let E0 be the edge at which iStart is sampled in IDLE.
  - LCD_RW/LCD_RS/oBusy go high at E0.
  - LCD_EN rises at E0+SETUP_CYC.
  - LCD_EN falls and data is latched at E0+SETUP_CYC+EN_WIDTH.
  - oDone is high for the cycle following E0+SETUP_CYC+EN_WIDTH+HOLD_CYC. With defaults this is E0+24.
- Each additional poll iteration adds exactly SETUP_CYC+EN_WIDTH+HOLD_CYC cycles. With defaults this is 24.
- A new iStart is accepted no earlier than the edge after oDone, which is the first IDLE cycle. Back-to-back single reads therefore take 26 cycles each with defaults.
- oDATA changes only at the latch edge. It is stable from that edge through oDone and beyond.

## Configuration
- LCD_RD_TIMEOUT_EN:
  - defined: a 16-bit poll counter increments per BF read. If the read count reaches TIMEOUT_POLLS with BF still 1, the block goes to DONE. oDone and oTimeout pulse together, and oDATA holds the last read (bit7=1).
  - undefined: polling is unbounded, oTimeout is tied 0, and the counter is absent.

## Test plan
- Single data read: iRS=1, iPoll=0, LCD_DATA_IN=8'h41 -> RW=1/RS=1, EN high cycles E0+4..E0+19, oDone at E0+24, oDATA=8'h41, oBusy falls after oDone.
- Poll: iPoll=1, iRS=1, model returns 8'h85, 8'h85, 8'h85, 8'h05 -> LCD_RS=0 throughout, 4 EN pulses, oDone at E0+96, oDATA=8'h05.
- Ignored start: iStart pulsed at E0+10 during a read -> no extra EN pulse, exactly one oDone.
- Reset mid-EN_HI: assert iRST_N=0 at E0+8 -> LCD_EN/LCD_RW/oBusy 0 immediately, oDATA=8'h00, no oDone; a new read after release completes normally.
- Timeout (macro defined, TIMEOUT_POLLS=3): model holds 8'h80 -> 3 EN pulses, oDone and oTimeout at E0+72, oDATA=8'h80. With the macro undefined, polling continues past 3 reads and oTimeout stays 0.
- Parameter sweep SETUP_CYC=1, EN_WIDTH=2, HOLD_CYC=1 -> oDone at E0+4, EN high exactly 2 cycles.
